// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and run-state type for the instruction fetch stage
package if_pkg;

    localparam logic [31:0] NOP_INST          = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/instr_memory.sv
// rtl/instr_memory.sv - single-clock instruction RAM, one sync read port and one sync write port
module instr_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // Write port: contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port, write-first on an address collision so a word loaded on the
    // same edge as the read is seen immediately.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, run-control FSM and IF/ID latch of the first pipeline stage
module instruction_fetch
    import if_pkg::*;
#(
    parameter int                    ADDR_BITS      = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    IMEM_ADDR_BITS = 10,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD      = DATA_WIDTH'(HALT_WORD_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [ADDR_BITS-1:0]      branch_target,
    input  logic                      prog_we,
    input  logic [IMEM_ADDR_BITS-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0]     prog_data,
    output logic [DATA_WIDTH-1:0]     inst_out,
    output logic [ADDR_BITS-1:0]      next_pc_out,
    output logic [ADDR_BITS-1:0]      pc_out,
    output logic                      running,
    output logic                      halted
);

    state_t                state, state_n;
    logic [ADDR_BITS-1:0]  pc, pc_n, pc_plus4, target_aligned, npc_n;
    logic [DATA_WIDTH-1:0] inst_n, mem_rdata;
    logic                  mem_re, mem_we;

    assign pc_plus4       = pc + ADDR_BITS'(4);
    assign target_aligned = branch_target & ~ADDR_BITS'(3);
    assign mem_we         = prog_we && (state != RUN);

    assign pc_out  = pc;
    assign running = (state == RUN);
    assign halted  = (state == HALTED);

    // The RAM is addressed with the upcoming PC, so mem_rdata always holds
    // mem[pc] and halt detection can be decided on the fetch edge itself.
    instr_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (IMEM_ADDR_BITS)
    ) u_imem (
        .clk   (clk),
        .re    (mem_re),
        .raddr (pc_n[IMEM_ADDR_BITS+1:2]),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data)
    );

    // Next-state, next-PC and IF/ID latch contents; branch beats stall beats halt.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = DATA_WIDTH'(NOP_INST);
        npc_n   = '0;
        mem_re  = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (branch_taken) begin
                    pc_n = target_aligned;
                end else if (stall) begin
                    inst_n = inst_out;
                    npc_n  = next_pc_out;
                    mem_re = 1'b0;
                end else if (mem_rdata == HALT_WORD) begin
                    state_n = HALTED;
                end else begin
                    inst_n = mem_rdata;
                    npc_n  = pc_plus4;
                    pc_n   = pc_plus4;
                end
            end
            HALTED: begin
                if (start) begin
                    state_n = IDLE;
                    pc_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, PC and IF/ID registers; reset aborts a run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            inst_out    <= DATA_WIDTH'(NOP_INST);
            next_pc_out <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            inst_out    <= inst_n;
            next_pc_out <= npc_n;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] WA = 32'h1000_0001;
    localparam logic [31:0] WB = 32'h2000_0002;
    localparam logic [31:0] WC = 32'h3000_0003;
    localparam logic [31:0] WD = 32'h4000_0004;
    localparam logic [31:0] WE = 32'h5000_0005;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [31:0] inst_out, next_pc_out, pc_out;
    logic        running, halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [1024];
    logic [31:0] m_pc, m_inst, m_npc;
    int          m_state;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .inst_out      (inst_out),
        .next_pc_out   (next_pc_out),
        .pc_out        (pc_out),
        .running       (running),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 0; m_inst = 0; m_npc = 0; m_state = 0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        case (m_state)
            0: begin
                if (prog_we) m_mem[prog_addr] = prog_data;
                m_inst = 0; m_npc = 0;
                if (start) m_state = 1;
            end
            1: begin
                if (branch_taken) begin
                    m_pc = (branch_target / 4) * 4;
                    m_inst = 0; m_npc = 0;
                end else if (!stall) begin
                    w = m_mem[(m_pc / 4) % 1024];
                    if (w == HALT) begin
                        m_inst = 0; m_npc = 0; m_state = 2;
                    end else begin
                        m_inst = w;
                        m_pc = m_pc + 4;
                        m_npc = m_pc;
                    end
                end
            end
            default: begin
                if (prog_we) m_mem[prog_addr] = prog_data;
                m_inst = 0; m_npc = 0;
                if (start) begin m_state = 0; m_pc = 0; end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a[9:0]; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic restart();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
    endtask

    task automatic mid_cycle_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({inst_out, next_pc_out, pc_out, running, halted} !== 98'd0) begin
            errors++;
            $display("FAIL reset_outputs: inst=%h npc=%h pc=%h run=%b halt=%b required all zero",
                     inst_out, next_pc_out, pc_out, running, halted);
        end
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            d = $urandom;
            if (d == HALT) d = 0;
            load(i, d);
        end
        checks++;
        if (running !== 1'b0 || pc_out !== 32'd0) begin
            errors++;
            $display("FAIL idle_after_load: run=%b pc=%h required run=0 pc=0", running, pc_out);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ei [4];
        logic [31:0] en [4];
        ei = '{WA, WB, WC, 32'd0};
        en = '{32'd4, 32'd8, 32'd12, 32'd0};
        load(0, WA); load(1, WB); load(2, WC); load(3, HALT);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (running !== 1'b1 || inst_out !== 32'd0 || pc_out !== 32'd0) begin
            errors++;
            $display("FAIL start_to_run: run=%b inst=%h pc=%h required 1 0 0", running, inst_out, pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (inst_out !== ei[i] || next_pc_out !== en[i]) begin
                errors++;
                $display("FAIL basic_fetch%0d: inst=%h npc=%h required %h %h",
                         i, inst_out, next_pc_out, ei[i], en[i]);
            end
        end
        checks++;
        if (halted !== 1'b1 || running !== 1'b0 || pc_out !== 32'd12) begin
            errors++;
            $display("FAIL basic_halt: halted=%b run=%b pc=%h required 1 0 0000000c", halted, running, pc_out);
        end
    endtask

    task automatic test_stall();
        restart();
        tick();
        tick();
        checks++;
        if (inst_out !== WB) begin
            errors++;
            $display("FAIL stall_setup: inst=%h required %h", inst_out, WB);
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (inst_out !== WB || next_pc_out !== 32'd8 || pc_out !== 32'd8) begin
                errors++;
                $display("FAIL stall_hold%0d: inst=%h npc=%h pc=%h required %h 8 8",
                         i, inst_out, next_pc_out, pc_out, WB);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (inst_out !== WC || next_pc_out !== 32'd12) begin
            errors++;
            $display("FAIL stall_resume: inst=%h npc=%h required %h c", inst_out, next_pc_out, WC);
        end
        tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL stall_halt: halted=%b required 1", halted);
        end
    endtask

    task automatic test_branch();
        load(8, WD); load(9, WE);
        restart();
        tick();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        checks++;
        if (inst_out !== 32'd0 || next_pc_out !== 32'd0 || pc_out !== 32'h20) begin
            errors++;
            $display("FAIL branch_bubble: inst=%h npc=%h pc=%h required 0 0 20", inst_out, next_pc_out, pc_out);
        end
        stall = 1'b0; branch_taken = 1'b0;
        tick();
        checks++;
        if (inst_out !== WD || next_pc_out !== 32'h24 || pc_out !== 32'h24) begin
            errors++;
            $display("FAIL branch_target_fetch: inst=%h npc=%h pc=%h required %h 24 24",
                     inst_out, next_pc_out, pc_out, WD);
        end
    endtask

    task automatic test_branch_align_halt();
        branch_taken = 1'b1; branch_target = 32'h23;
        tick();
        checks++;
        if (pc_out !== 32'h20 || inst_out !== 32'd0) begin
            errors++;
            $display("FAIL branch_align: pc=%h inst=%h required 20 0", pc_out, inst_out);
        end
        branch_target = 32'hC;
        tick();
        checks++;
        if (inst_out !== 32'd0 || pc_out !== 32'hC || running !== 1'b1) begin
            errors++;
            $display("FAIL branch_to_halt_bubble: inst=%h pc=%h run=%b required 0 c 1", inst_out, pc_out, running);
        end
        branch_taken = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b1 || inst_out !== 32'd0 || pc_out !== 32'hC) begin
            errors++;
            $display("FAIL branch_then_halt: halted=%b inst=%h pc=%h required 1 0 c", halted, inst_out, pc_out);
        end
    endtask

    task automatic test_prog_in_run();
        restart();
        tick();
        prog_we = 1'b1; prog_addr = 10'd1; prog_data = 32'h5555_5555;
        tick();
        checks++;
        if (inst_out !== WB) begin
            errors++;
            $display("FAIL prog_run_fetch_b: inst=%h required %h", inst_out, WB);
        end
        prog_addr = 10'd2;
        tick();
        prog_we = 1'b0;
        checks++;
        if (inst_out !== WC) begin
            errors++;
            $display("FAIL prog_run_fetch_c: inst=%h required %h", inst_out, WC);
        end
        tick();
        restart();
        tick();
        tick();
        checks++;
        if (inst_out !== WB) begin
            errors++;
            $display("FAIL prog_readback_b: inst=%h required %h", inst_out, WB);
        end
        tick();
        checks++;
        if (inst_out !== WC) begin
            errors++;
            $display("FAIL prog_readback_c: inst=%h required %h", inst_out, WC);
        end
        tick();
    endtask

    task automatic test_async_reset();
        restart();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({inst_out, next_pc_out, pc_out, running, halted} !== 98'd0) begin
            errors++;
            $display("FAIL async_reset: inst=%h npc=%h pc=%h run=%b halt=%b required all zero",
                     inst_out, next_pc_out, pc_out, running, halted);
        end
        model_reset();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (inst_out !== WA || next_pc_out !== 32'd4) begin
            errors++;
            $display("FAIL rerun_after_reset: inst=%h npc=%h required %h 4", inst_out, next_pc_out, WA);
        end
        tick();
        checks++;
        if (inst_out !== WB) begin
            errors++;
            $display("FAIL memory_retained: inst=%h required %h", inst_out, WB);
        end
    endtask

    task automatic test_random();
        mid_cycle_reset();
        for (int i = 0; i < 40; i++) load($urandom_range(4, 1023), HALT);
        for (int n = 0; n < 3000; n++) begin
            start         = ($urandom_range(0, 3) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095));
            prog_we       = ($urandom_range(0, 2) == 0);
            prog_addr     = 10'($urandom);
            prog_data     = ($urandom_range(0, 7) == 0) ? HALT : 32'($urandom);
            tick();
            checks++;
            if (inst_out !== m_inst || next_pc_out !== m_npc || pc_out !== m_pc ||
                running !== (m_state == 1) || halted !== (m_state == 2)) begin
                errors++;
                $display("FAIL random_cycle%0d: inst=%h npc=%h pc=%h run=%b halt=%b required %h %h %h %b %b",
                         n, inst_out, next_pc_out, pc_out, running, halted,
                         m_inst, m_npc, m_pc, (m_state == 1), (m_state == 2));
            end
        end
        start = 1'b0; stall = 1'b0; branch_taken = 1'b0; prog_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_branch_align_halt();
        test_prog_in_run();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
